// File: rtl/vga_mem_read_arbiter_if.sv
// Avalon-MM style read-only bus bundle shared by the two video requesters and the memory port.
// The master modport issues reads; the slave modport answers them.
interface vga_mem_read_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 16
);
    logic                    read;
    logic [ADDR_WIDTH-1:0]   address;
    logic [DATA_WIDTH/8-1:0] byteenable;
    logic                    waitrequest;
    logic [DATA_WIDTH-1:0]   readdata;
    logic                    readdatavalid;

    modport master (
        output read, address, byteenable,
        input  waitrequest, readdata, readdatavalid
    );

    modport slave (
        input  read, address, byteenable,
        output waitrequest, readdata, readdatavalid
    );
endinterface

// File: rtl/vga_mem_read_arbiter.sv
// Two-requester round-robin read arbiter (frame stream s0, sprite stream s1) onto one pipelined
// memory port; an in-order owner FIFO routes each returning word back to the requester that issued it.
module vga_mem_read_arbiter #(
    parameter int MM_ADDR_WIDTH     = 32,
    parameter int MM_DATA_WIDTH     = 16,
    parameter int MAX_PENDING_READS = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    vga_mem_read_arbiter_if.slave         s0,
    vga_mem_read_arbiter_if.slave         s1,
    vga_mem_read_arbiter_if.master        m,
    output logic                          error
);
    localparam int PTR_W = $clog2(MAX_PENDING_READS);
    localparam int CNT_W = $clog2(MAX_PENDING_READS + 1);

    typedef enum logic [1:0] {
        ST_FREE  = 2'd0,
        ST_LOCK0 = 2'd1,
        ST_LOCK1 = 2'd2
    } state_t;

    state_t             state_q;
    logic               last_grant_q;
    logic               error_q;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               owner_q [MAX_PENDING_READS];

    logic [1:0]         req_read;
    logic [1:0]         req_wait;
    logic [1:0]         req_rvalid;
    logic               grant;
    logic               grant_valid;
    logic               violation;
    logic               full;
    logic               fwd;
    logic               accept;
    logic               rvalid_in;
    logic               pop;
    logic               orphan;
    logic               head_owner;

    assign req_read = {s1.read, s0.read};

    // A locked owner keeps the bus; dropping its read while locked is a protocol violation.
    always_comb begin
        grant       = 1'b0;
        grant_valid = 1'b0;
        violation   = 1'b0;
        case (state_q)
            ST_LOCK0: begin
                grant       = 1'b0;
                grant_valid = req_read[0];
                violation   = !req_read[0];
            end
            ST_LOCK1: begin
                grant       = 1'b1;
                grant_valid = req_read[1];
                violation   = !req_read[1];
            end
            default: begin
                if (req_read[0] && req_read[1]) begin
                    grant       = !last_grant_q;
                    grant_valid = 1'b1;
                end else if (req_read[1]) begin
                    grant       = 1'b1;
                    grant_valid = 1'b1;
                end else begin
                    grant       = 1'b0;
                    grant_valid = req_read[0];
                end
            end
        endcase
    end

    // Full is judged on the registered count only, so a same-cycle return never reopens the port.
    assign full       = (count_q == CNT_W'(MAX_PENDING_READS));
    assign fwd        = grant_valid && !full && !reset;
    assign accept     = fwd && !m.waitrequest;
    assign rvalid_in  = m.readdatavalid && !reset;
    assign pop        = rvalid_in && (count_q != '0);
    assign orphan     = rvalid_in && (count_q == '0);
    assign head_owner = owner_q[rd_ptr_q];

    assign m.read       = fwd;
    assign m.address    = fwd ? (grant ? s1.address : s0.address) : '0;
    assign m.byteenable = fwd ? (grant ? s1.byteenable : s0.byteenable) : '0;

    for (genvar gi = 0; gi < 2; gi++) begin : g_req
        assign req_wait[gi]   = !(accept && (grant == 1'(gi)));
        assign req_rvalid[gi] = pop && (head_owner == 1'(gi));
    end

    assign s0.waitrequest   = req_wait[0];
    assign s1.waitrequest   = req_wait[1];
    assign s0.readdatavalid = req_rvalid[0];
    assign s1.readdatavalid = req_rvalid[1];
    assign s0.readdata      = m.readdata;
    assign s1.readdata      = m.readdata;
    assign error            = error_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (accept) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (accept && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!accept && pop) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            owner_q[wr_ptr_q] <= grant;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_FREE;
            last_grant_q <= 1'b1;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            error_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_LOCK0, ST_LOCK1: begin
                    if (violation || accept) begin
                        state_q <= ST_FREE;
                    end
                end
                default: begin
                    if (fwd && m.waitrequest) begin
                        state_q <= grant ? ST_LOCK1 : ST_LOCK0;
                    end
                end
            endcase
            if (accept) begin
                last_grant_q <= grant;
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (orphan || violation) begin
                error_q <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_vga_mem_read_arbiter.sv
// Directed bench: a fixed-latency memory model answers accepted reads; every cycle checks request
// gating and response routing, and each scenario compares accept order/timing with hand-derived tables.
module tb_vga_mem_read_arbiter;
    localparam int MAXP = 4;

    logic clk = 1'b0;
    logic reset;
    logic err;

    vga_mem_read_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(16)) s0_if ();
    vga_mem_read_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(16)) s1_if ();
    vga_mem_read_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(16)) m_if ();

    vga_mem_read_arbiter #(
        .MM_ADDR_WIDTH(32),
        .MM_DATA_WIDTH(16),
        .MAX_PENDING_READS(MAXP)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .s0    (s0_if.slave),
        .s1    (s1_if.slave),
        .m     (m_if.master),
        .error (err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int lat      = 6;
    bit inject   = 1'b0;

    bit        sched_v [64];
    logic [15:0] sched_d [64];
    bit        exp_owner [$];
    logic [15:0] exp_data [$];
    int        acc_cyc [$];
    bit        acc_owner [$];
    bit        last_acc_valid;
    bit        last_acc_owner;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end else begin
            n_pass++;
        end
    endtask

    function automatic logic [15:0] mem_word(input logic [31:0] a);
        return a[15:0] ^ 16'hC3A5;
    endfunction

    task automatic flush_model();
        exp_owner.delete();
        exp_data.delete();
        for (int i = 0; i < 64; i++) sched_v[i] = 1'b0;
    endtask

    // One clock: entered and left at a falling edge, stimulus already applied.
    task automatic cycle();
        int  slot;
        bit  ret;
        bit  eo;
        bit  owner;
        logic [15:0] ed;
        slot = cyc % 64;
        ret  = sched_v[slot];
        last_acc_valid = 1'b0;
        m_if.readdatavalid = 1'b0;
        m_if.readdata      = 16'h0000;
        if (ret) begin
            m_if.readdatavalid = 1'b1;
            m_if.readdata      = sched_d[slot];
            sched_v[slot]      = 1'b0;
        end else if (inject) begin
            m_if.readdatavalid = 1'b1;
            m_if.readdata      = 16'hDEAD;
        end
        #1;
        if (reset) begin
            check("rst_mread", m_if.read, 0);
            check("rst_wr0", s0_if.waitrequest, 1);
            check("rst_wr1", s1_if.waitrequest, 1);
            check("rst_rv0", s0_if.readdatavalid, 0);
            check("rst_rv1", s1_if.readdatavalid, 0);
        end else begin
            if (!m_if.read) check("addr_idle", m_if.address, 0);
            if (exp_owner.size() == MAXP) check("full_block", m_if.read, 0);
            if (ret && exp_owner.size() != 0) begin
                eo = exp_owner.pop_front();
                ed = exp_data.pop_front();
                check("rv0", s0_if.readdatavalid, (eo == 1'b0));
                check("rv1", s1_if.readdatavalid, (eo == 1'b1));
                check("rdata", eo ? s1_if.readdata : s0_if.readdata, ed);
                $display("cyc %0d: return s%0d data=%04h", cyc, eo, ed);
            end else begin
                check("rv0_idle", s0_if.readdatavalid, 0);
                check("rv1_idle", s1_if.readdatavalid, 0);
            end
            if (m_if.read && !m_if.waitrequest) begin
                owner = (m_if.address >= 32'd1024);
                check("acc_wr_own", owner ? s1_if.waitrequest : s0_if.waitrequest, 0);
                check("acc_wr_other", owner ? s0_if.waitrequest : s1_if.waitrequest, 1);
                exp_owner.push_back(owner);
                exp_data.push_back(mem_word(m_if.address));
                sched_v[(cyc + lat) % 64] = 1'b1;
                sched_d[(cyc + lat) % 64] = mem_word(m_if.address);
                acc_cyc.push_back(cyc);
                acc_owner.push_back(owner);
                last_acc_valid = 1'b1;
                last_acc_owner = owner;
                $display("cyc %0d: accept s%0d addr=%08h", cyc, owner, m_if.address);
            end else begin
                check("wr0_hold", s0_if.waitrequest, 1);
                check("wr1_hold", s1_if.waitrequest, 1);
            end
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        flush_model();
        repeat (n) cycle();
        reset = 1'b0;
    endtask

    task automatic set_req(input bit r0, input int a0, input bit r1, input int a1);
        s0_if.read = r0; s0_if.address = 32'(a0); s0_if.byteenable = 2'b11;
        s1_if.read = r1; s1_if.address = 32'(a1); s1_if.byteenable = 2'b11;
    endtask

    // Streams n0/n1 reads then waits for every response, bounded by maxc cycles.
    task automatic run_stream(input int n0, input int n1, input int b0, input int b1, input int maxc);
        int i0 = 0;
        int i1 = 0;
        int k  = 0;
        acc_cyc.delete();
        acc_owner.delete();
        while ((i0 < n0 || i1 < n1 || exp_owner.size() != 0) && k < maxc) begin
            set_req(i0 < n0, b0 + 2 * i0, i1 < n1, b1 + 2 * i1);
            cycle();
            if (last_acc_valid) begin
                if (last_acc_owner) i1++; else i0++;
            end
            k++;
        end
        check("stream_done", (k < maxc), 1);
        set_req(0, 0, 0, 0);
    endtask

    int t1_rel [8] = '{0, 1, 2, 3, 7, 8, 9, 10};
    int c0;

    initial begin
        reset = 1'b1;
        set_req(0, 0, 0, 0);
        m_if.waitrequest = 1'b0;
        m_if.readdata = 16'h0000;
        m_if.readdatavalid = 1'b0;
        flush_model();
        @(negedge clk);

        // Reset with a live request and a stray response: both must be ignored.
        set_req(1, 16, 0, 0);
        inject = 1'b1;
        do_reset(3);
        inject = 1'b0;
        set_req(0, 0, 0, 0);
        #1 check("err_after_rst", err, 0);
        check("mread_idle", m_if.read, 0);

        // s0 alone, 8 reads, latency 6: four back-to-back, stall, then refill as data returns.
        c0 = cyc;
        run_stream(8, 0, 0, 1024, 80);
        check("t1_nacc", acc_cyc.size(), 8);
        for (int i = 0; i < 8 && i < acc_cyc.size(); i++) begin
            check("t1_acc_cyc", acc_cyc[i] - c0, t1_rel[i]);
            check("t1_owner", acc_owner[i], 0);
        end

        // Continuous dual contention: accepts alternate starting with s0.
        do_reset(1);
        run_stream(6, 6, 256, 1024, 120);
        check("t2_nacc", acc_owner.size(), 12);
        for (int i = 0; i < 12 && i < acc_owner.size(); i++) begin
            check("t2_alt", acc_owner[i], i % 2);
        end

        // LOCK1: s1 granted under waitrequest keeps the grant and a stable address.
        do_reset(1);
        set_req(1, 32, 0, 0);
        cycle();
        check("t3_first_s0", {last_acc_valid, last_acc_owner}, 2'b10);
        set_req(1, 34, 1, 1056);
        m_if.waitrequest = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("lock1_mread", m_if.read, 1);
            check("lock1_addr", m_if.address, 1056);
            check("lock1_wr0", s0_if.waitrequest, 1);
            cycle();
        end
        m_if.waitrequest = 1'b0;
        cycle();
        check("lock1_acc", {last_acc_valid, last_acc_owner}, 2'b11);
        set_req(1, 34, 0, 0);
        cycle();
        check("after_lock1_s0", {last_acc_valid, last_acc_owner}, 2'b10);

        // LOCK0 must hold s0 even though round-robin alone would now favour s1.
        set_req(1, 48, 0, 0);
        m_if.waitrequest = 1'b1;
        cycle();
        set_req(1, 48, 1, 1072);
        #1 check("lock0_addr", m_if.address, 48);
        cycle();
        m_if.waitrequest = 1'b0;
        cycle();
        check("lock0_acc", {last_acc_valid, last_acc_owner}, 2'b10);
        set_req(0, 0, 1, 1072);
        cycle();
        check("after_lock0_s1", {last_acc_valid, last_acc_owner}, 2'b11);
        run_stream(0, 0, 0, 1024, 20);

        // Orphan response with nothing pending.
        #1 check("err_pre_orphan", err, 0);
        inject = 1'b1;
        cycle();
        inject = 1'b0;
        #1 check("err_orphan", err, 1);
        repeat (3) cycle();
        #1 check("err_sticky", err, 1);

        // Reset with two reads outstanding; afterwards four accepts fit back-to-back.
        lat = 20;
        set_req(1, 64, 0, 0);
        cycle();
        set_req(1, 66, 0, 0);
        cycle();
        check("t4_pending", exp_owner.size(), 2);
        set_req(1, 68, 0, 0);
        do_reset(2);
        set_req(0, 0, 0, 0);
        lat = 6;
        #1 check("err_cleared", err, 0);
        c0 = cyc;
        run_stream(4, 0, 80, 1024, 40);
        check("t4_nacc", acc_cyc.size(), 4);
        for (int i = 0; i < 4 && i < acc_cyc.size(); i++) begin
            check("t4_acc_cyc", acc_cyc[i] - c0, i);
        end

        // Dropping read while locked: error, back to FREE, nothing pushed.
        set_req(1, 96, 0, 0);
        m_if.waitrequest = 1'b1;
        cycle();
        set_req(0, 0, 0, 0);
        cycle();
        m_if.waitrequest = 1'b0;
        #1 check("err_violation", err, 1);
        c0 = cyc;
        run_stream(4, 0, 112, 1024, 40);
        check("t5_nacc", acc_cyc.size(), 4);
        for (int i = 0; i < 4 && i < acc_cyc.size(); i++) begin
            check("t5_acc_cyc", acc_cyc[i] - c0, i);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
